// File: rtl/uart_rx.sv
// UART receiver: two-flop input synchronizer, start-bit qualification at
// mid-bit, LSB-first payload sampling at bit centres, and stop-bit
// classification into one of three single-cycle pulses (valid / break /
// frame error).
module uart_rx #(
    parameter int BIT_RATE     = 115200,
    parameter int CLK_HZ       = 50_000_000,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    output logic                    uart_rx_break,
    output logic                    uart_rx_valid,
    output logic                    uart_rx_frame_err,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data
);

    localparam int BIT_P          = 1_000_000_000 / BIT_RATE;
    localparam int CLK_P          = 1_000_000_000 / CLK_HZ;
    localparam int CYCLES_PER_BIT = BIT_P / CLK_P;
    localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
    localparam int COUNT_W        = 1 + $clog2(CYCLES_PER_BIT);

    // The cycle counter is cleared on every phase change, so a span of N
    // cycles is complete on the cycle the register holds N-1. Comparing
    // against N-1 keeps every sampled bit exactly CYCLES_PER_BIT long and
    // avoids drift across the frame.
    localparam logic [COUNT_W-1:0] BIT_LAST  = COUNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [COUNT_W-1:0] HALF_LAST = COUNT_W'(HALF_BIT - 1);
    localparam logic [3:0]         LAST_BIT  = 4'(PAYLOAD_BITS - 1);

    // Only the first stop bit is checked; any further stop bits are idle-high
    // time absorbed by IDLE. The 4-bit bit counter bounds the payload size.
    if (PAYLOAD_BITS < 2 || PAYLOAD_BITS > 15 || STOP_BITS < 1) begin : g_param_check
        $error("uart_rx: unsupported PAYLOAD_BITS/STOP_BITS combination");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RECV  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                    state, state_next;
    logic [COUNT_W-1:0]        cnt, cnt_next;
    logic [3:0]                bit_cnt, bit_cnt_next;
    logic [PAYLOAD_BITS-1:0]   payload, payload_next;
    logic [PAYLOAD_BITS-1:0]   data_next;
    logic                      valid_next, break_next, ferr_next;
    logic                      rxd_m, rxd_s, rxd_prev;
    logic                      rxd_fall;

    // Synchronize the asynchronous pin and keep one cycle of history for edge detection.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rxd_m    <= 1'b1;
            rxd_s    <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_m    <= uart_rxd;
            rxd_s    <= rxd_m;
            rxd_prev <= rxd_s;
        end
    end

    // A frame may only start on a genuine high-to-low transition, so a line
    // left low after a break or reset never retriggers by itself.
    assign rxd_fall = rxd_prev & ~rxd_s;

    // State, counters, payload and registered output pulses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state             <= IDLE;
            cnt               <= '0;
            bit_cnt           <= '0;
            payload           <= '0;
            uart_rx_data      <= '0;
            uart_rx_valid     <= 1'b0;
            uart_rx_break     <= 1'b0;
            uart_rx_frame_err <= 1'b0;
        end else begin
            state             <= state_next;
            cnt               <= cnt_next;
            bit_cnt           <= bit_cnt_next;
            payload           <= payload_next;
            uart_rx_data      <= data_next;
            uart_rx_valid     <= valid_next;
            uart_rx_break     <= break_next;
            uart_rx_frame_err <= ferr_next;
        end
    end

    // Next-state and datapath decisions; pulses default low so each fires for one cycle.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        bit_cnt_next = bit_cnt;
        payload_next = payload;
        data_next    = uart_rx_data;
        valid_next   = 1'b0;
        break_next   = 1'b0;
        ferr_next    = 1'b0;

        case (state)
            IDLE: begin
                cnt_next     = '0;
                bit_cnt_next = '0;
                // Enable is only looked at here; a frame in flight always completes.
                if (uart_rx_en && rxd_fall) begin
                    state_next = START;
                end
            end

            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_next   = '0;
                    // Line back high at mid start bit means it was a glitch.
                    state_next = rxd_s ? IDLE : RECV;
                end else begin
                    cnt_next = cnt + COUNT_W'(1);
                end
            end

            RECV: begin
                if (cnt == BIT_LAST) begin
                    cnt_next     = '0;
                    payload_next = {rxd_s, payload[PAYLOAD_BITS-1:1]};
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_next = '0;
                        state_next   = STOP;
                    end else begin
                        bit_cnt_next = bit_cnt + 4'd1;
                    end
                end else begin
                    cnt_next = cnt + COUNT_W'(1);
                end
            end

            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                    if (rxd_s) begin
                        valid_next = 1'b1;
                        data_next  = payload;
                    end else if (payload == '0) begin
                        break_next = 1'b1;
                    end else begin
                        ferr_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt + COUNT_W'(1);
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at default parameters (434 cycles per bit).
module tb_uart_rx;

    localparam int CPB = 434;

    logic       clk = 1'b0;
    logic       resetn;
    logic       uart_rxd;
    logic       uart_rx_en;
    logic       uart_rx_break;
    logic       uart_rx_valid;
    logic       uart_rx_frame_err;
    logic [7:0] uart_rx_data;

    always #10 clk = ~clk;

    uart_rx dut (
        .clk               (clk),
        .resetn            (resetn),
        .uart_rxd          (uart_rxd),
        .uart_rx_en        (uart_rx_en),
        .uart_rx_break     (uart_rx_break),
        .uart_rx_valid     (uart_rx_valid),
        .uart_rx_frame_err (uart_rx_frame_err),
        .uart_rx_data      (uart_rx_data)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Pulse monitor: counts events, logs data on valid, flags overlap or stretched pulses.
    int         n_valid = 0, n_break = 0, n_ferr = 0, mon_err = 0, valid_cyc = 0;
    logic [7:0] vq[$];
    logic       prev_v = 1'b0, prev_b = 1'b0, prev_f = 1'b0;

    always @(negedge clk) begin
        if (uart_rx_valid) begin
            n_valid   <= n_valid + 1;
            valid_cyc <= cyc;
            vq.push_back(uart_rx_data);
        end
        if (uart_rx_break)     n_break <= n_break + 1;
        if (uart_rx_frame_err) n_ferr  <= n_ferr + 1;
        if ((int'(uart_rx_valid) + int'(uart_rx_break) + int'(uart_rx_frame_err)) > 1 ||
            (uart_rx_valid && prev_v) || (uart_rx_break && prev_b) ||
            (uart_rx_frame_err && prev_f))
            mon_err <= mon_err + 1;
        prev_v <= uart_rx_valid;
        prev_b <= uart_rx_break;
        prev_f <= uart_rx_frame_err;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one 8N1 frame; returns the cycle on which the start bit began.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input logic drop_en, output int fall);
        uart_rxd = 1'b0;
        fall     = cyc;
        wait_cyc(CPB);
        if (drop_en) uart_rx_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            wait_cyc(CPB);
        end
        uart_rxd = stop_bit;
        wait_cyc(CPB);
    endtask

    initial begin
        int         fall, lat, nv, nb, nf, qs;
        logic [7:0] part;

        resetn     = 1'b0;
        uart_rxd   = 1'b1;
        uart_rx_en = 1'b1;
        wait_cyc(5);
        @(negedge clk);
        chk("rst_data",  32'(uart_rx_data), 32'h00);
        chk("rst_valid", 32'(uart_rx_valid), 32'h0);
        chk("rst_break", 32'(uart_rx_break), 32'h0);
        chk("rst_ferr",  32'(uart_rx_frame_err), 32'h0);
        chk("rst_state", 32'(dut.state), 32'h0);
        chk("rst_sync",  32'(dut.rxd_s), 32'h1);
        @(posedge clk);
        #1 resetn = 1'b1;
        wait_cyc(10);

        // Basic frame and latency from the falling edge.
        nv = n_valid;
        send_frame(8'hA5, 1'b1, 1'b0, fall);
        wait_cyc(20);
        chk("a5_count", 32'(n_valid), 32'(nv + 1));
        chk("a5_data",  32'(uart_rx_data), 32'hA5);
        lat = valid_cyc - fall;
        tests++;
        assert (lat >= 4123 && lat <= 4127)
        else begin
            fails++;
            $error("FAIL a5_latency: observed %0d cycles expected 4125 +/- 2", lat);
        end

        // 100-cycle glitch: rejected at mid start bit, no pulse.
        nv = n_valid; nb = n_break; nf = n_ferr;
        uart_rxd = 1'b0;
        wait_cyc(100);
        uart_rxd = 1'b1;
        wait_cyc(125);
        chk("glitch_idle", 32'(dut.state), 32'h0);
        wait_cyc(600);
        chk("glitch_nvalid", 32'(n_valid), 32'(nv));
        chk("glitch_nbreak", 32'(n_break), 32'(nb));
        chk("glitch_nferr",  32'(n_ferr), 32'(nf));

        // Low stop bit with non-zero payload: frame error, data held.
        nv = n_valid; nf = n_ferr;
        send_frame(8'h3C, 1'b0, 1'b0, fall);
        uart_rxd = 1'b1;
        wait_cyc(50);
        chk("ferr_count",  32'(n_ferr), 32'(nf + 1));
        chk("ferr_nvalid", 32'(n_valid), 32'(nv));
        chk("ferr_data",   32'(uart_rx_data), 32'hA5);

        // Line low for 12 bit times: one break, no retrigger while low.
        nv = n_valid; nb = n_break; nf = n_ferr;
        uart_rxd = 1'b0;
        wait_cyc(12 * CPB);
        uart_rxd = 1'b1;
        wait_cyc(2 * CPB);
        chk("brk_count",  32'(n_break), 32'(nb + 1));
        chk("brk_nvalid", 32'(n_valid), 32'(nv));
        chk("brk_nferr",  32'(n_ferr), 32'(nf));
        chk("brk_data",   32'(uart_rx_data), 32'hA5);
        send_frame(8'h5A, 1'b1, 1'b0, fall);
        wait_cyc(20);
        chk("post_brk_count", 32'(n_valid), 32'(nv + 1));
        chk("post_brk_data",  32'(uart_rx_data), 32'h5A);

        // Enable low in IDLE: frame ignored.
        nv = n_valid;
        uart_rx_en = 1'b0;
        send_frame(8'h33, 1'b1, 1'b0, fall);
        wait_cyc(20);
        chk("en_off_nvalid", 32'(n_valid), 32'(nv));
        uart_rx_en = 1'b1;
        wait_cyc(10);

        // Enable dropped mid-frame: frame still completes.
        send_frame(8'h96, 1'b1, 1'b1, fall);
        uart_rx_en = 1'b1;
        wait_cyc(20);
        chk("en_drop_count", 32'(n_valid), 32'(nv + 1));
        chk("en_drop_data",  32'(uart_rx_data), 32'h96);

        // Reset during bit 4: partial frame discarded, data cleared.
        nv = n_valid; nb = n_break; nf = n_ferr;
        part     = 8'hC3;
        uart_rxd = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 4; i++) begin
            uart_rxd = part[i];
            wait_cyc(CPB);
        end
        uart_rxd = part[4];
        wait_cyc(200);
        resetn   = 1'b0;
        uart_rxd = 1'b1;
        wait_cyc(3);
        resetn = 1'b1;
        wait_cyc(12 * CPB);
        chk("rstmid_nvalid", 32'(n_valid), 32'(nv));
        chk("rstmid_nbreak", 32'(n_break), 32'(nb));
        chk("rstmid_nferr",  32'(n_ferr), 32'(nf));
        chk("rstmid_data",   32'(uart_rx_data), 32'h00);
        send_frame(8'hFF, 1'b1, 1'b0, fall);
        wait_cyc(20);
        chk("ff_count", 32'(n_valid), 32'(nv + 1));
        chk("ff_data",  32'(uart_rx_data), 32'hFF);

        // Back-to-back frames with no idle gap.
        nv = n_valid; nb = n_break;
        qs = vq.size();
        send_frame(8'h01, 1'b1, 1'b0, fall);
        send_frame(8'h80, 1'b1, 1'b0, fall);
        send_frame(8'h00, 1'b1, 1'b0, fall);
        wait_cyc(20);
        chk("b2b_count",  32'(n_valid), 32'(nv + 3));
        chk("b2b_nbreak", 32'(n_break), 32'(nb));
        if (vq.size() >= qs + 3) begin
            chk("b2b_first",  32'(vq[qs]),     32'h01);
            chk("b2b_second", 32'(vq[qs + 1]), 32'h80);
            chk("b2b_third",  32'(vq[qs + 2]), 32'h00);
        end
        chk("b2b_data", 32'(uart_rx_data), 32'h00);

        chk("pulse_shape", 32'(mon_err), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
